// File: rtl/adc_pair_sequencer.sv
// Acquisition sequencer for two AD7643 converters in serial slave mode: converts,
// waits out BUSY, shifts both results in parallel and writes enabled channels to memory.
module adc_pair_sequencer #(
  parameter int CNV_LOW   = 4,
  parameter int SCLK_HALF = 2,
  parameter int NBITS     = 18,
  parameter int ADRW      = 14,
  parameter int TMO       = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            clradr_i,
  input  logic [ADRW-1:0] nsamp_i,
  input  logic [1:0]      chen_i,
  output logic            adcnvst0_o,
  output logic            adcnvst1_o,
  output logic            adcs0_o,
  output logic            adcs1_o,
  output logic            adsclk0_o,
  output logic            adsclk1_o,
  input  logic            adbusy0_i,
  input  logic            adbusy1_i,
  input  logic            adsdout0_i,
  input  logic            adsdout1_i,
  output logic            memwe_o,
  output logic [ADRW-1:0] memadr_o,
  output logic [15:0]     memdat_o,
  output logic            run_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int CW = 16;
  localparam int BW = $clog2(NBITS);
  localparam logic [CW-1:0] CNV_LAST   = CW'(CNV_LOW - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TMO + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, CONV, WBUSY, SHIFT, WR0, WR1, NEXT, FIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bitCnt_q, bitCnt_d;
  logic              lead_q, lead_d;
  logic              sclkHigh_q, sclkHigh_d;
  logic [NBITS-1:0]  shift0_q, shift0_d, shift1_q, shift1_d;
  logic [ADRW-1:0]   ptr_q, ptr_d;
  logic [ADRW-1:0]   sampCnt_q, sampCnt_d;
  logic [ADRW-1:0]   nsamp_q, nsamp_d;
  logic [1:0]        chen_q, chen_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              stopPend_q, stopPend_d;
  logic              busyAny;

  assign busyAny = (chen_q[0] && adbusy0_i) || (chen_q[1] && adbusy1_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitCnt_q   <= '0;
      lead_q     <= 1'b0;
      sclkHigh_q <= 1'b0;
      shift0_q   <= '0;
      shift1_q   <= '0;
      ptr_q      <= '0;
      sampCnt_q  <= '0;
      nsamp_q    <= '0;
      chen_q     <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      stopPend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitCnt_q   <= bitCnt_d;
      lead_q     <= lead_d;
      sclkHigh_q <= sclkHigh_d;
      shift0_q   <= shift0_d;
      shift1_q   <= shift1_d;
      ptr_q      <= ptr_d;
      sampCnt_q  <= sampCnt_d;
      nsamp_q    <= nsamp_d;
      chen_q     <= chen_d;
      run_q      <= run_d;
      done_q     <= done_d;
      err_q      <= err_d;
      stopPend_q <= stopPend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitCnt_d   = bitCnt_q;
    lead_d     = lead_q;
    sclkHigh_d = sclkHigh_q;
    shift0_d   = shift0_q;
    shift1_d   = shift1_q;
    ptr_d      = ptr_q;
    sampCnt_d  = sampCnt_q;
    nsamp_d    = nsamp_q;
    chen_d     = chen_q;
    run_d      = run_q;
    done_d     = 1'b0;
    err_d      = err_q;
    stopPend_d = stopPend_q;
    if (stop_i && state_q != IDLE) stopPend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        // Pointer clear is applied first so a simultaneous START begins at address 0.
        if (clradr_i) ptr_d = '0;
        if (start_i) begin
          if (chen_i != 2'b00) begin
            nsamp_d    = nsamp_i;
            chen_d     = chen_i;
            err_d      = 1'b0;
            sampCnt_d  = '0;
            stopPend_d = 1'b0;
            run_d      = 1'b1;
            cnt_d      = '0;
            state_d    = CONV;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      CONV: begin
        if (cnt_q == CNV_LAST) begin
          cnt_d   = '0;
          state_d = WBUSY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WBUSY: begin
        if (cnt_q > BLANK_LAST && !busyAny) begin
          cnt_d      = '0;
          bitCnt_d   = '0;
          lead_d     = 1'b1;
          sclkHigh_d = 1'b0;
          state_d    = SHIFT;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          run_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // One chip-select lead cycle, then NBITS low/high SCLK periods; data taken at end of low.
        if (lead_q) begin
          lead_d = 1'b0;
        end else if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d      = '0;
          sclkHigh_d = !sclkHigh_q;
          if (!sclkHigh_q) begin
            shift0_d = {shift0_q[NBITS-2:0], adsdout0_i};
            shift1_d = {shift1_q[NBITS-2:0], adsdout1_i};
          end else if (bitCnt_q == BIT_LAST) begin
            state_d = chen_q[0] ? WR0 : (chen_q[1] ? WR1 : NEXT);
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      WR0: begin
        ptr_d   = ptr_q + 1'b1;
        state_d = chen_q[1] ? WR1 : NEXT;
      end
      WR1: begin
        ptr_d   = ptr_q + 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        sampCnt_d = sampCnt_q + 1'b1;
        if ((sampCnt_q + 1'b1) == nsamp_q || stopPend_q || stop_i) begin
          run_d   = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      FIN: begin
        stopPend_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign adcnvst0_o = !(state_q == CONV && chen_q[0]);
  assign adcnvst1_o = !(state_q == CONV && chen_q[1]);
  assign adcs0_o    = !(state_q == SHIFT && chen_q[0]);
  assign adcs1_o    = !(state_q == SHIFT && chen_q[1]);
  assign adsclk0_o  = state_q == SHIFT && sclkHigh_q && chen_q[0];
  assign adsclk1_o  = state_q == SHIFT && sclkHigh_q && chen_q[1];
  assign memwe_o    = state_q == WR0 || state_q == WR1;
  assign memadr_o   = ptr_q;
  assign memdat_o   = (state_q == WR0) ? shift0_q[NBITS-1 -: 16] :
                      (state_q == WR1) ? shift1_q[NBITS-1 -: 16] : 16'h0000;
  assign run_o      = run_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_adc_pair_sequencer.sv
// Bench for adc_pair_sequencer: behavioural ADC models feed random samples and a
// queue-based reference predicts every memory write from the run parameters.
module tb_adc_pair_sequencer;
  localparam int ADRW  = 5;
  localparam int TMO   = 255;
  localparam int DEPTH = 1 << ADRW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0, stop_i = 1'b0, clradr_i = 1'b0;
  logic [ADRW-1:0] nsamp_i = '0;
  logic [1:0]      chen_i = '0;
  logic            adcnvst0_o, adcnvst1_o, adcs0_o, adcs1_o, adsclk0_o, adsclk1_o;
  logic            busy0 = 1'b0, busy1 = 1'b0, sdout0 = 1'b0, sdout1 = 1'b0;
  logic            memwe_o, run_o, done_o, err_o;
  logic [ADRW-1:0] memadr_o;
  logic [15:0]     memdat_o;

  int vectors = 0;
  int miscompares = 0;
  int modelPtr = 0;
  int busyLat = 0;
  bit stuckBusy = 1'b0;
  bit fixedMode = 1'b0;
  logic [17:0] fixed0 = '0, fixed1 = '0, word0 = '0, word1 = '0;
  int bitIdx0 = 0, bitIdx1 = 0;
  logic [17:0] words0[$], words1[$];
  logic [ADRW-1:0] wrA[$];
  logic [15:0] wrD[$];
  time fall0[$];

  always #5 clk = ~clk;

  adc_pair_sequencer #(.ADRW(ADRW), .TMO(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .stop_i(stop_i), .clradr_i(clradr_i),
    .nsamp_i(nsamp_i), .chen_i(chen_i),
    .adcnvst0_o(adcnvst0_o), .adcnvst1_o(adcnvst1_o), .adcs0_o(adcs0_o), .adcs1_o(adcs1_o),
    .adsclk0_o(adsclk0_o), .adsclk1_o(adsclk1_o), .adbusy0_i(busy0), .adbusy1_i(busy1),
    .adsdout0_i(sdout0), .adsdout1_i(sdout1), .memwe_o(memwe_o), .memadr_o(memadr_o),
    .memdat_o(memdat_o), .run_o(run_o), .done_o(done_o), .err_o(err_o)
  );

  // Converter models: new word per conversion, BUSY released busyLat cycles after CNVST rises.
  always @(negedge adcnvst0_o) begin
    word0 = fixedMode ? fixed0 : 18'($urandom);
    words0.push_back(word0);
    fall0.push_back($time);
    busy0 = 1'b1;
  end
  always @(negedge adcnvst1_o) begin
    word1 = fixedMode ? fixed1 : 18'($urandom);
    words1.push_back(word1);
    busy1 = 1'b1;
  end
  always @(posedge adcnvst0_o) if (!stuckBusy) begin
    repeat (busyLat) @(posedge clk);
    busy0 = 1'b0;
  end
  always @(posedge adcnvst1_o) if (!stuckBusy) begin
    repeat (busyLat) @(posedge clk);
    busy1 = 1'b0;
  end
  always @(negedge adcs0_o) begin bitIdx0 = 17; sdout0 = word0[17]; end
  always @(negedge adcs1_o) begin bitIdx1 = 17; sdout1 = word1[17]; end
  always @(negedge adsclk0_o) if (bitIdx0 > 0) begin bitIdx0--; sdout0 = word0[bitIdx0]; end
  always @(negedge adsclk1_o) if (bitIdx1 > 0) begin bitIdx1--; sdout1 = word1[bitIdx1]; end

  always @(negedge clk) if (rst_n && memwe_o) begin
    wrA.push_back(memadr_o);
    wrD.push_back(memdat_o);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: START pulse, optional STOP during sample stopAt's shift, optional START while busy.
  task automatic applyStimulus(input logic [1:0] chen, input logic [ADRW-1:0] nsamp,
                               input bit clr, input int stopAt, input bit midStart);
    int ns, cyc, convs;
    bit doneSeen, stopped;
    logic [ADRW-1:0] expA[$];
    logic [15:0] expD[$];
    words0.delete(); words1.delete(); wrA.delete(); wrD.delete(); fall0.delete();
    @(negedge clk);
    chen_i = chen; nsamp_i = nsamp; start_i = 1'b1; clradr_i = clr;
    @(negedge clk);
    start_i = 1'b0; clradr_i = 1'b0;
    if (clr) modelPtr = 0;
    checkOutput("runAtN1", run_o, chen != 2'b00);
    checkOutput("cnvst0AtN1", adcnvst0_o, !chen[0]);
    checkOutput("cnvst1AtN1", adcnvst1_o, !chen[1]);
    doneSeen = done_o; cyc = 0; stopped = 1'b0;
    while (!doneSeen && cyc < 20000) begin
      @(negedge clk);
      cyc++; start_i = 1'b0; stop_i = 1'b0;
      convs = chen[0] ? words0.size() : words1.size();
      if (stopAt >= 0 && !stopped && convs == stopAt + 1 && (chen[0] ? !adcs0_o : !adcs1_o)) begin
        stop_i = 1'b1; stopped = 1'b1;
      end
      if (midStart && cyc == 30) begin
        start_i = 1'b1; chen_i = ~chen; nsamp_i = ADRW'(7);
      end
      doneSeen = done_o;
    end
    start_i = 1'b0; stop_i = 1'b0;
    checkOutput("doneSeen", doneSeen, 1);
    checkOutput("runAtDone", run_o, 0);
    @(negedge clk);
    checkOutput("donePulse", done_o, 0);
    if (chen == 2'b00) ns = 0;
    else if (stopAt >= 0) ns = stopAt + 1;
    else ns = (nsamp == 0) ? DEPTH : int'(nsamp);
    checkOutput("conv0", words0.size(), chen[0] ? ns : 0);
    checkOutput("conv1", words1.size(), chen[1] ? ns : 0);
    for (int i = 0; i < ns; i++) begin
      if (chen[0] && i < words0.size()) begin
        expA.push_back(ADRW'(modelPtr)); expD.push_back(words0[i][17:2]);
        modelPtr = (modelPtr + 1) % DEPTH;
      end
      if (chen[1] && i < words1.size()) begin
        expA.push_back(ADRW'(modelPtr)); expD.push_back(words1[i][17:2]);
        modelPtr = (modelPtr + 1) % DEPTH;
      end
    end
    checkOutput("wrCount", wrA.size(), ns * (int'(chen[0]) + int'(chen[1])));
    for (int i = 0; i < expA.size() && i < wrA.size(); i++) begin
      checkOutput("wrAddr", wrA[i], expA[i]);
      checkOutput("wrData", wrD[i], expD[i]);
    end
  endtask

  initial begin
    int cyc, n;
    repeat (3) @(negedge clk);
    checkOutput("rstCnvst0", adcnvst0_o, 1);
    checkOutput("rstCnvst1", adcnvst1_o, 1);
    checkOutput("rstCs0", adcs0_o, 1);
    checkOutput("rstCs1", adcs1_o, 1);
    checkOutput("rstSclk0", adsclk0_o, 0);
    checkOutput("rstSclk1", adsclk1_o, 0);
    checkOutput("rstMemwe", memwe_o, 0);
    checkOutput("rstMemadr", memadr_o, 0);
    checkOutput("rstMemdat", memdat_o, 0);
    checkOutput("rstRun", run_o, 0);
    checkOutput("rstDone", done_o, 0);
    checkOutput("rstErr", err_o, 0);
    rst_n = 1'b1;

    fixedMode = 1'b1; fixed0 = 18'h2AAAA; fixed1 = 18'h15555; busyLat = 10;
    applyStimulus(2'd3, ADRW'(1), 1'b0, -1, 1'b0);
    if (wrD.size() == 2) begin
      checkOutput("pairWord0", wrD[0], 16'hAAAA);
      checkOutput("pairWord1", wrD[1], 16'h5555);
    end
    fixedMode = 1'b0;

    busyLat = 0;
    applyStimulus(2'd3, ADRW'(2), 1'b0, -1, 1'b0);
    checkOutput("period", (fall0.size() == 2) ? 32'((fall0[1] - fall0[0]) / 10) : 32'd0, 83);

    for (int r = 0; r < 5; r++) begin
      busyLat = $urandom_range(0, 12);
      applyStimulus(2'($urandom_range(1, 3)), ADRW'($urandom_range(1, 3)), 1'b0, -1, r == 1);
    end

    applyStimulus(2'd0, ADRW'(2), 1'b0, -1, 1'b0);

    @(negedge clk); clradr_i = 1'b1;
    @(negedge clk); clradr_i = 1'b0; modelPtr = 0;
    applyStimulus(2'd1, ADRW'(2), 1'b0, -1, 1'b0);
    applyStimulus(2'd3, ADRW'(1), 1'b1, -1, 1'b0);

    busyLat = 0;
    applyStimulus(2'd2, ADRW'(0), 1'b0, -1, 1'b0);
    applyStimulus(2'd2, ADRW'(31), 1'b1, -1, 1'b0);
    applyStimulus(2'd2, ADRW'(1), 1'b0, -1, 1'b0);
    if (wrA.size() == 1) checkOutput("wrapTop", wrA[0], DEPTH - 1);
    applyStimulus(2'd2, ADRW'(1), 1'b0, -1, 1'b0);
    if (wrA.size() == 1) checkOutput("wrapZero", wrA[0], 0);

    applyStimulus(2'd3, ADRW'(20), 1'b0, 3, 1'b0);

    // BUSY never falls: expect abort with ERR and DONE together, nothing written.
    words0.delete(); wrA.delete(); wrD.delete();
    stuckBusy = 1'b1;
    @(negedge clk); chen_i = 2'd1; nsamp_i = ADRW'(1); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (adcnvst0_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    n = 0;
    while (err_o !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checkOutput("tmoCycles", n, 2 + TMO);
    checkOutput("tmoDone", done_o, 1);
    checkOutput("tmoRun", run_o, 0);
    checkOutput("tmoCs0", adcs0_o, 1);
    @(negedge clk);
    checkOutput("tmoDonePulse", done_o, 0);
    checkOutput("tmoNoWrite", wrA.size(), 0);
    checkOutput("tmoErrSticky", err_o, 1);
    stuckBusy = 1'b0; busy0 = 1'b0;
    applyStimulus(2'd1, ADRW'(1), 1'b0, -1, 1'b0);
    checkOutput("errCleared", err_o, 0);

    // Asynchronous reset while SCLK is high in the middle of a shift.
    @(negedge clk); chen_i = 2'd3; nsamp_i = ADRW'(5); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (adcs0_o !== 1'b0 && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (7) @(negedge clk);
    checkOutput("preRstSclk", adsclk0_o, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arstCs0", adcs0_o, 1);
    checkOutput("arstCs1", adcs1_o, 1);
    checkOutput("arstSclk0", adsclk0_o, 0);
    checkOutput("arstSclk1", adsclk1_o, 0);
    checkOutput("arstMemwe", memwe_o, 0);
    checkOutput("arstRun", run_o, 0);
    checkOutput("arstMemadr", memadr_o, 0);
    @(negedge clk); rst_n = 1'b1; modelPtr = 0;
    applyStimulus(2'd1, ADRW'(2), 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/adc_pair_sequencer.md
# adc_pair_sequencer

Acquisition sequencer for the two AD7643 ADCs on the board, running in serial slave mode. It issues conversions on both converters, waits out BUSY, and shifts in both 18-bit results on parallel serial clocks. It writes the enabled channels' samples through one shared write port into the waveform memory that the FT600 transfer path later drains. The command decoder drives it: command 5 maps to START, command 2 to CLRADR, command 6 to STOP.

## Interface
- CNV_LOW, 4: CLK cycles ADCNVSTx held low per conversion (≥1).
- SCLK_HALF, 2: CLK cycles per SCLK half-period (≥1).
- NBITS, 18: bits shifted per conversion.
- ADRW, 14: memory address width.
- TMO, 255: max CLK cycles waiting for BUSY low before abort.

- CLK  in  1  system clock; all logic on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle pulse; begins a run when idle.
- STOP  in  1  one-cycle pulse; ends the run after the current sample.
- CLRADR  in  1  one-cycle pulse; clears the write pointer to 0 (idle only).
- NSAMP  in  ADRW  sample pairs per run, latched at START; 0 means 2^ADRW.
- CHEN  in  2  channel enable, bit0 = ADC0, bit1 = ADC1; latched at START.
- ADCNVST0/1  out  1  conversion start, active-low.
- ADCS0/1  out  1  chip select, active-low.
- ADSCLK0/1  out  1  serial clock.
- ADBUSY0/1  in  1  converter busy, active-high.
- ADSDOUT0/1  in  1  serial data, MSB first.
- MEMWE  out  1  write strobe, one cycle per word.
- MEMADR  out  ADRW  write address.
- MEMDAT  out  16  write data = sample[NBITS-1:NBITS-16].
- RUN  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse at the end of a run.
- ERR  out  1  sticky BUSY-timeout flag; cleared by the next accepted START.

## Operation
- Reset values: ADCNVSTx=1, ADCSx=1, ADSCLKx=0, MEMWE=0, MEMADR=0, MEMDAT=0, RUN=0, DONE=0, ERR=0; state IDLE; pointer and sample counter 0.
- States: IDLE → CONV → WBUSY → SHIFT → WR0 → WR1 → NEXT → (CONV | FIN) ; FIN → IDLE.
- IDLE: START with CHEN≠0 latches NSAMP/CHEN, clears ERR and the sample counter, and goes to CONV. START with CHEN=0 only pulses DONE next cycle. CLRADR sets pointer 0. START and CLRADR together: clear the pointer first, then start the run at address 0.
- CONV: enabled ADCNVSTx low for CNV_LOW cycles, then high. Disabled channels keep all their outputs at reset values.
- WBUSY: ignores BUSY for 2 cycles, then waits until every enabled ADBUSYx=0. More than TMO cycles of waiting sets ERR, returns all ADC outputs to their reset values, pulses DONE, and goes to IDLE; nothing is written.
- SHIFT: enabled ADCSx low one cycle before the first SCLK. NBITS periods follow, each SCLK_HALF cycles low then SCLK_HALF high. ADSDOUTx is sampled on the last CLK cycle of each low phase. After the last high phase, SCLK goes 0 and ADCSx goes 1.
- WR0 (if CHEN[0]): MEMWE=1, MEMDAT=ch0 data, MEMADR=pointer; pointer+1 the next cycle. WR1 does the same for CHEN[1]. Disabled channels' states take 0 cycles. Channel 0 always writes before channel 1 (fixed priority).
- Pointer wraps 2^ADRW−1 → 0 silently.
- NEXT: sample counter+1. If the counter equals NSAMP (mod 2^ADRW) or STOP is pending, go to FIN. Otherwise go to CONV.
- STOP while running is held pending until NEXT. STOP in IDLE is ignored. START while RUN=1 is ignored.
- FIN: DONE=1 for one cycle, RUN=0.

## Timing
- START sampled at edge N → RUN=1 and first ADCNVST low at N+1.
- Per-sample period = CNV_LOW + 2 + Tbusy + 1 + 2·SCLK_HALF·NBITS + 1 + (#enabled) + 1 cycles.
- With defaults and Tbusy=0 this is 4+2+1+72+1+2+1 = 83 cycles for two channels.
- MEMWE never asserts outside WR0/WR1; at most one write per cycle.
- Asynchronous reset mid-run returns every output to its reset value immediately. Pointer returns to 0; partial samples are discarded.

## Test plan
- Reset then idle: RSTN low mid-SHIFT → ADCS0/1=1, ADSCLK=0, MEMWE=0, RUN=0 asynchronously.
- Single pair: CHEN=3, NSAMP=1, ADSDOUT0 pattern 0x2AAAA, ADSDOUT1 pattern 0x15555, BUSY low after 10 cycles → writes 0xAAAA@0 then 0x5555@1, DONE 1 cycle, RUN low.
- Single channel, wrap: CHEN=2, pointer preset by 16383 runs of NSAMP=1 → next write at 16383, following run writes at 0.
- Timeout: ADBUSY0 held high → ERR=1 after 2+TMO cycles of WBUSY, DONE pulse, no MEMWE. Next START clears ERR.
- STOP mid-run: NSAMP=100, STOP during sample 3 SHIFT → samples 0–3 written (8 words), DONE, no 5th CONV.
- Corner pulses: START with CHEN=0 → DONE only. START and CLRADR in the same cycle → first write at 0. START while RUN → ignored.
